// File: rtl/blink_code_tx.sv
// Status LED code transmitter: plays each accepted code as N blinks,
// then a long dark gap, with a one-deep holding register for the next code.
//
// Ports:
//   clock       in  system clock, all logic on posedge
//   reset_n     in  asynchronous active-low reset
//   code        in  blink count to transmit (CODE_W bits)
//   code_valid  in  code offered; held stable until accepted
//   code_ready  out holding register empty (accept on valid && ready)
//   led         out registered LED drive, active-high
//   busy        out playing a code or holding one
//   done        out one-cycle pulse when a code's final gap completes
module blink_code_tx #(
    parameter int CODE_W  = 4,
    parameter int ON_CYC  = 6000000,
    parameter int OFF_CYC = 6000000,
    parameter int GAP_CYC = 24000000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic              code_ready,
    output logic              led,
    output logic              busy,
    output logic              done
);

    localparam int MAX_ON_OFF = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int MAX_CYC    = (MAX_ON_OFF > GAP_CYC) ? MAX_ON_OFF : GAP_CYC;
    localparam int CNT_W      = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CODE_W-1:0] REM_ONE  = CODE_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [CODE_W-1:0] rem;
    logic [CODE_W-1:0] pend;
    logic              pend_v;
    logic              at_end;
    logic              load;
    logic              accept;

    // Last cycle of the current timed state.
    always_comb begin
        at_end = 1'b0;
        case (state)
            S_ON:    at_end = (cnt == ON_LAST);
            S_OFF:   at_end = (cnt == OFF_LAST);
            S_GAP:   at_end = (cnt == GAP_LAST);
            default: at_end = 1'b0;
        endcase
    end

    // A held code starts from IDLE, or straight out of the previous
    // code's gap so back-to-back codes have no idle cycle between them.
    assign load   = pend_v && ((state == S_IDLE) ||
                               ((state == S_GAP) && at_end));
    assign accept = code_valid && !pend_v;

    assign code_ready = !pend_v;
    assign busy       = (state != S_IDLE) || pend_v;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rem    <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            led    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= (state == S_GAP) && at_end;

            // accept needs an empty register, load a full one: exclusive.
            if (accept) begin
                pend   <= code;
                pend_v <= 1'b1;
            end else if (load) begin
                pend_v <= 1'b0;
            end

            if (load) begin
                rem <= pend;
                cnt <= '0;
                if (pend != '0) begin
                    state <= S_ON;
                    led   <= 1'b1;
                end else begin
                    state <= S_GAP;
                    led   <= 1'b0;
                end
            end else begin
                case (state)
                    S_ON: begin
                        if (at_end) begin
                            cnt <= '0;
                            rem <= rem - REM_ONE;
                            led <= 1'b0;
                            // Last blink skips OFF and goes to the gap.
                            state <= (rem > REM_ONE) ? S_OFF : S_GAP;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_OFF: begin
                        if (at_end) begin
                            cnt   <= '0;
                            led   <= 1'b1;
                            state <= S_ON;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_GAP: begin
                        if (at_end) begin
                            cnt   <= '0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        cnt <= '0;
                        led <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
